nios2_oci_dct_packer: RTL and testbench
=======================================

NIOS2_OCI_DCT_PACKER -- requirements
Module: nios2_oci_dct_packer

Interface
REQ-001 Parameter FLUSH_TIMEOUT, default 255, idle cycles before a partial buffer is force-flushed; 0 disables the timeout; legal range 0..255.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 atom_valid  input  1  trace atom present this cycle.
REQ-005 atom  input  2  trace atom value.
REQ-006 flush  input  1  one-cycle request to emit the partial buffer.
REQ-007 test_ending  input  1  drain request; latched sticky internally.
REQ-008 clr_overflow  input  1  clears the overflow flag.
REQ-009 dct_buffer  output  30  live packing buffer.
REQ-010 dct_count  output  4  atoms held in dct_buffer, 0..15.
REQ-011 out_data  output  30  emitted frame.
REQ-012 out_count  output  4  atom count of the emitted frame, 1..15.
REQ-013 out_valid  output  1  frame available.
REQ-014 out_ready  input  1  consumer accepts the frame when out_valid and out_ready are both high.
REQ-015 overflow  output  1  sticky: at least one atom was dropped.
REQ-016 test_has_ended  output  1  sticky: drain complete.

Function
REQ-017 Atom packing: atom k is written to dct_buffer[2k+1:2k], LSB-first; the unused bits above 2*dct_count are 0.
REQ-018 Output register:
- Empty when out_valid=0, or when out_valid=1 and out_ready=1 in the current cycle.
- Transfer loads out_data/out_count from dct_buffer/dct_count, sets out_valid, and clears dct_buffer and dct_count.
REQ-019 A transfer is triggered by any of the following, provided dct_count>0 and the output register is empty:
- dct_count=15
- flush (pending)
- timeout
- test_ending latched
REQ-020 A trigger that arrives while the output register is full shall remain pending until the register empties; a flush with dct_count=0 is discarded.
REQ-021 Atom arriving on a transfer cycle: it is written to bit slot 0 of the cleared buffer, and dct_count becomes 1 the next cycle.
REQ-022 Atom arriving with dct_count=15 and no transfer that cycle: the atom is dropped, overflow is set, and the buffer is unchanged.
REQ-023 Priority when clr_overflow and a drop occur in the same cycle: overflow stays 1.
REQ-024 Idle timer:
- Counts cycles with dct_count>0 and atom_valid=0.
- Clears on any accepted atom or on any transfer.
- Reaching FLUSH_TIMEOUT raises a timeout trigger.
- Saturates at the FLUSH_TIMEOUT value; never wraps.
REQ-025 State machine:
- States: EMPTY, FILL, FULL_WAIT, DRAIN, ENDED.
- EMPTY -> FILL on the first atom.
- FILL -> FULL_WAIT when dct_count=15 and the output register is full.
- FULL_WAIT -> FILL on transfer.
- Any state -> DRAIN when test_ending is latched.
- DRAIN -> ENDED when dct_count=0 and out_valid=0.
REQ-026 In DRAIN and ENDED, atom_valid is ignored: no packing, and overflow is not set.
REQ-027 test_has_ended rises in the first ENDED cycle and holds until reset.
REQ-028 out_data, out_count and out_valid are stable while out_valid=1 and out_ready=0.

Reset
REQ-029 reset_n=0 asynchronously forces all of the following:
- dct_buffer=0, dct_count=0
- out_data=0, out_count=0, out_valid=0
- overflow=0, test_has_ended=0
- idle timer=0, latched test_ending and pending triggers cleared
- state=EMPTY
REQ-030 Reset asserted mid-frame discards the partial buffer and any pending frame; no transfer occurs on the cycle reset_n deasserts.

Verification
REQ-031 Fill: 15 atoms 0,1,2,3,0,1,... with out_ready=1 -> one frame, out_count=15, out_data=30'h24E4E4E4 (atom values 0,1,2,3 repeating at 2-bit slots), then dct_count=0.
REQ-032 Backpressure: out_ready=0, 31 atoms all =3 -> first frame held; second buffer reaches 15 with dct_buffer=30'h3FFFFFFF; 31st atom dropped and overflow=1; after out_ready=1, two frames emitted, each count 15.
REQ-033 Timeout: FLUSH_TIMEOUT=4, 3 atoms (1,2,3), then idle -> frame out_data=30'h39, out_count=3 on the 4th idle cycle's transfer.
REQ-034 Flush collision: flush asserted on the same cycle as the 1st atom of an empty buffer -> flush held pending, frame with out_count=1 transfers next cycle; flush with dct_count=0 -> no frame.
REQ-035 Drain: 5 atoms buffered, frame pending, test_ending pulse with out_ready=0 for 10 cycles then 1 -> both frames emitted in order; test_has_ended=1 after the last accept; later atoms ignored.
REQ-036 Reset mid-frame: 7 atoms, then reset_n=0 for 1 cycle -> all outputs 0 immediately, with no frame emitted after release.

Source files
------------

// File: rtl/nios2_oci_dct_packer.sv
// nios2_oci_dct_packer: packs 2-bit trace atoms into 15-atom frames with flush, timeout and drain control
module nios2_oci_dct_packer #(
  parameter int unsigned FLUSH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        atom_valid,
  input  logic [1:0]  atom,
  input  logic        flush,
  input  logic        test_ending,
  input  logic        clr_overflow,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic [29:0] out_data,
  output logic [3:0]  out_count,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow,
  output logic        test_has_ended
);
  typedef enum logic [2:0] {EMPTY, FILL, FULL_WAIT, DRAIN, ENDED} state_t;
  state_t      r_state;
  logic [29:0] r_buf, r_odata;
  logic [3:0]  r_cnt, r_ocnt;
  logic [7:0]  r_idle;
  logic        r_ovalid, r_ov, r_ended, r_te, r_fp;
  logic        w_av, w_free, w_idle_cyc, w_tmo, w_xfer, w_acc, w_drop, w_drained;
  logic [8:0]  w_idle_nx;
  logic [29:0] w_base, w_buf_nx;
  logic [3:0]  w_bcnt, w_cnt_nx;
  // Atoms are ignored once draining starts; a transfer frees slot 0 for an atom arriving the same cycle
  always_comb begin
    w_av       = atom_valid && r_state != DRAIN && r_state != ENDED;
    w_free     = !r_ovalid || out_ready;
    w_idle_cyc = r_cnt != 4'd0 && !w_av;
    w_idle_nx  = {1'b0, r_idle} + {8'd0, w_idle_cyc};
    w_tmo      = FLUSH_TIMEOUT != 0 && w_idle_nx >= 9'(FLUSH_TIMEOUT);
    w_xfer     = r_cnt != 4'd0 && w_free && (r_cnt == 4'd15 || flush || r_fp || r_te || w_tmo);
    w_acc      = w_av && (w_xfer || r_cnt != 4'd15);
    w_drop     = w_av && !w_acc;
    w_base     = w_xfer ? 30'd0 : r_buf;
    w_bcnt     = w_xfer ? 4'd0 : r_cnt;
    w_buf_nx   = w_acc ? w_base | (30'(atom) << {w_bcnt, 1'b0}) : w_base;
    w_cnt_nx   = w_bcnt + {3'd0, w_acc};
    w_drained  = r_state == DRAIN && r_cnt == 4'd0 && !r_ovalid;
  end
  // Packing buffer, output register, sticky flags, idle timer and control FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= EMPTY;
      r_buf    <= '0;
      r_cnt    <= '0;
      r_odata  <= '0;
      r_ocnt   <= '0;
      r_ovalid <= 1'b0;
      r_ov     <= 1'b0;
      r_ended  <= 1'b0;
      r_te     <= 1'b0;
      r_fp     <= 1'b0;
      r_idle   <= '0;
    end else begin
      r_buf  <= w_buf_nx;
      r_cnt  <= w_cnt_nx;
      if (w_xfer) begin
        r_odata  <= r_buf;
        r_ocnt   <= r_cnt;
        r_ovalid <= 1'b1;
      end else if (r_ovalid && out_ready) r_ovalid <= 1'b0;
      r_ov    <= w_drop ? 1'b1 : clr_overflow ? 1'b0 : r_ov;
      r_fp    <= w_xfer ? 1'b0 : r_fp || (flush && (r_cnt != 4'd0 || w_acc));
      r_idle  <= (w_xfer || w_acc) ? 8'd0 : (w_idle_cyc && r_idle < 8'(FLUSH_TIMEOUT)) ? r_idle + 8'd1 : r_idle;
      r_te    <= r_te || test_ending;
      r_ended <= r_ended || w_drained;
      if (r_state == ENDED) r_state <= ENDED;
      else if (test_ending || r_te) r_state <= w_drained ? ENDED : DRAIN;
      else if (r_state == EMPTY && w_acc) r_state <= FILL;
      else if (r_state == FILL && r_cnt == 4'd15 && !w_free) r_state <= FULL_WAIT;
      else if (r_state == FULL_WAIT && w_xfer) r_state <= FILL;
    end
  end
  assign dct_buffer     = r_buf;
  assign dct_count      = r_cnt;
  assign out_data       = r_odata;
  assign out_count      = r_ocnt;
  assign out_valid      = r_ovalid;
  assign overflow       = r_ov;
  assign test_has_ended = r_ended;
endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// tb_nios2_oci_dct_packer: randomized and directed checks against a queue-based frame model
module tb_nios2_oci_dct_packer;
  localparam int T = 4;
  logic clk = 1'b0, reset_n = 1'b0;
  logic atom_valid = 1'b0, flush = 1'b0, test_ending = 1'b0, clr_overflow = 1'b0, out_ready = 1'b0;
  logic [1:0] atom = 2'd0;
  logic [29:0] dct_buffer, out_data;
  logic [3:0] dct_count, out_count;
  logic out_valid, overflow, test_has_ended;
  int n_cmp = 0, n_bad = 0;
  int m_q[$];
  logic [29:0] m_od;
  int m_oc, m_idle;
  bit m_ovalid, m_ovf, m_end, m_te, m_fp, m_drain;
  int acc_cnt[$];
  logic [29:0] acc_data[$];

  nios2_oci_dct_packer #(.FLUSH_TIMEOUT(T)) dut (
    .clk(clk), .reset_n(reset_n), .atom_valid(atom_valid), .atom(atom), .flush(flush),
    .test_ending(test_ending), .clr_overflow(clr_overflow), .dct_buffer(dct_buffer),
    .dct_count(dct_count), .out_data(out_data), .out_count(out_count), .out_valid(out_valid),
    .out_ready(out_ready), .overflow(overflow), .test_has_ended(test_has_ended)
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] pack();
    logic [29:0] r = '0;
    foreach (m_q[k]) r = r | (30'(m_q[k]) << (2 * k));
    return r;
  endfunction

  function automatic logic [70:0] m_vec();
    return {pack(), 4'(m_q.size()), m_od, 4'(m_oc), m_ovalid, m_ovf, m_end};
  endfunction

  function automatic logic [70:0] dut_vec();
    return {dct_buffer, dct_count, out_data, out_count, out_valid, overflow, test_has_ended};
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_od = '0; m_oc = 0; m_idle = 0;
    m_ovalid = 0; m_ovf = 0; m_end = 0; m_te = 0; m_fp = 0; m_drain = 0;
  endtask

  task automatic cycle(input bit av, input logic [1:0] a, input bit fl, input bit te, input bit clr, input bit rdy);
    bit avv, free, ic, tmo, x, drop, endc;
    int n, t;
    atom_valid = av; atom = a; flush = fl; test_ending = te; clr_overflow = clr; out_ready = rdy;
    avv = av && !m_drain;
    n = m_q.size();
    free = !m_ovalid || rdy;
    ic = n > 0 && !avv;
    t = m_idle + (ic ? 1 : 0);
    tmo = T > 0 && t >= T;
    x = n > 0 && free && (n == 15 || fl || m_fp || m_te || tmo);
    drop = avv && !x && n == 15;
    endc = m_drain && n == 0 && !m_ovalid;
    if (out_valid && out_ready) begin
      acc_cnt.push_back(int'(out_count));
      acc_data.push_back(out_data);
    end
    if (x) begin
      m_od = pack(); m_oc = n; m_ovalid = 1; m_q.delete();
    end else if (m_ovalid && rdy) m_ovalid = 0;
    if (avv && !drop) m_q.push_back(int'(a));
    m_ovf = drop ? 1'b1 : clr ? 1'b0 : m_ovf;
    m_fp = x ? 1'b0 : (m_fp || (fl && (n > 0 || avv)));
    m_idle = (x || (avv && !drop)) ? 0 : (ic && m_idle < T) ? m_idle + 1 : m_idle;
    m_end = m_end || endc;
    m_drain = m_drain || te || m_te;
    m_te = m_te || te;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    atom_valid = 0; flush = 0; test_ending = 0; clr_overflow = 0; out_ready = 0;
    m_reset();
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (dut_vec() !== 71'd0) begin n_bad++; $display("FAIL reset_state got %h want 0", dut_vec()); end
    do_reset();
    cycle(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (dut_vec() !== m_vec()) begin n_bad++; $display("FAIL reset_idle got %h want %h", dut_vec(), m_vec()); end
  endtask

  task automatic test_fill();
    bit seen = 0;
    acc_cnt.delete(); acc_data.delete();
    for (int i = 0; i < 15; i++) begin
      cycle(1, 2'(i % 4), 0, 0, 0, 1);
      n_cmp++;
      if (dut_vec() !== m_vec()) begin n_bad++; $display("FAIL fill_step%0d got %h want %h", i, dut_vec(), m_vec()); end
    end
    for (int i = 0; i < 5 && !seen; i++) begin
      cycle(0, 0, 0, 0, 0, 1);
      if (out_valid) seen = 1;
    end
    n_cmp++;
    if (!seen || out_count !== 4'd15 || out_data !== 30'h24E4E4E4 || dct_count !== 4'd0) begin
      n_bad++; $display("FAIL fill_frame got v=%0b cnt=%0d data=%h dc=%0d want 1/15/24e4e4e4/0", seen, out_count, out_data, dct_count);
    end
    cycle(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_backpressure();
    acc_cnt.delete(); acc_data.delete();
    for (int i = 0; i < 30; i++) cycle(1, 2'd3, 0, 0, 0, 0);
    n_cmp++;
    if (dct_buffer !== 30'h3FFFFFFF || dct_count !== 4'd15 || !out_valid || overflow !== 1'b0) begin
      n_bad++; $display("FAIL bp_full got buf=%h cnt=%0d ov=%0b want 3fffffff/15/0", dct_buffer, dct_count, overflow);
    end
    cycle(1, 2'd3, 0, 0, 0, 0);
    n_cmp++;
    if (overflow !== 1'b1 || dct_buffer !== 30'h3FFFFFFF || dct_count !== 4'd15) begin
      n_bad++; $display("FAIL bp_drop got ov=%0b buf=%h cnt=%0d want 1/3fffffff/15", overflow, dct_buffer, dct_count);
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (acc_cnt.size() != 2 || acc_cnt[0] != 15 || acc_cnt[1] != 15) begin
      n_bad++; $display("FAIL bp_frames got n=%0d want 2 frames of 15", acc_cnt.size());
    end
    cycle(0, 0, 0, 0, 1, 1);
    n_cmp++;
    if (overflow !== 1'b0 || dut_vec() !== m_vec()) begin n_bad++; $display("FAIL bp_clr got %h want %h", dut_vec(), m_vec()); end
  endtask

  task automatic test_timeout();
    cycle(1, 2'd1, 0, 0, 0, 1);
    cycle(1, 2'd2, 0, 0, 0, 1);
    cycle(1, 2'd3, 0, 0, 0, 1);
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 0, 0, 0, 0, 1);
      n_cmp++;
      if (out_valid !== (i == 4)) begin n_bad++; $display("FAIL timeout_idle%0d got v=%0b want %0b", i, out_valid, i == 4); end
    end
    n_cmp++;
    if (out_data !== 30'h39 || out_count !== 4'd3) begin n_bad++; $display("FAIL timeout_frame got %h/%0d want 39/3", out_data, out_count); end
    cycle(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_flush();
    cycle(1, 2'd2, 1, 0, 0, 1);
    n_cmp++;
    if (out_valid !== 1'b0 || dct_count !== 4'd1) begin n_bad++; $display("FAIL flush_hold got v=%0b cnt=%0d want 0/1", out_valid, dct_count); end
    cycle(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_count !== 4'd1 || out_data !== 30'h2) begin
      n_bad++; $display("FAIL flush_frame got v=%0b cnt=%0d d=%h want 1/1/2", out_valid, out_count, out_data);
    end
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0, 1);
      n_cmp++;
      if (out_valid !== 1'b0 || dut_vec() !== m_vec()) begin n_bad++; $display("FAIL flush_empty got %h want %h", dut_vec(), m_vec()); end
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 9) < 6, 2'($urandom), $urandom_range(0, 19) == 0, 0, $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
      n_cmp++;
      if (dut_vec() !== m_vec()) begin
        n_bad++; bad++;
        if (bad < 10) $display("FAIL random_cyc%0d got %h want %h", i, dut_vec(), m_vec());
      end
    end
  endtask

  task automatic test_drain();
    logic [1:0] v[20];
    logic [29:0] f0 = '0, f1 = '0;
    do_reset();
    acc_cnt.delete(); acc_data.delete();
    for (int i = 0; i < 20; i++) begin
      v[i] = 2'($urandom);
      if (i < 15) f0 = f0 | (30'(v[i]) << (2 * i)); else f1 = f1 | (30'(v[i]) << (2 * (i - 15)));
      cycle(1, v[i], 0, 0, 0, 0);
    end
    cycle(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 9; i++) begin
      cycle(0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (dut_vec() !== m_vec()) begin n_bad++; $display("FAIL drain_hold got %h want %h", dut_vec(), m_vec()); end
    end
    for (int i = 0; i < 10 && !test_has_ended; i++) begin
      cycle(0, 0, 0, 0, 0, 1);
      n_cmp++;
      if (dut_vec() !== m_vec()) begin n_bad++; $display("FAIL drain_step got %h want %h", dut_vec(), m_vec()); end
    end
    n_cmp++;
    if (test_has_ended !== 1'b1 || acc_cnt.size() != 2) begin
      n_bad++; $display("FAIL drain_end got ended=%0b frames=%0d want 1/2", test_has_ended, acc_cnt.size());
    end else begin
      n_cmp++;
      if (acc_cnt[0] != 15 || acc_data[0] !== f0 || acc_cnt[1] != 5 || acc_data[1] !== f1) begin
        n_bad++; $display("FAIL drain_order got %0d:%h %0d:%h want 15:%h 5:%h", acc_cnt[0], acc_data[0], acc_cnt[1], acc_data[1], f0, f1);
      end
    end
    for (int i = 0; i < 20; i++) cycle(1, 2'd3, 0, 0, 0, 1);
    n_cmp++;
    if (dct_count !== 4'd0 || overflow !== 1'b0 || test_has_ended !== 1'b1) begin
      n_bad++; $display("FAIL drain_ignore got cnt=%0d ov=%0b end=%0b want 0/0/1", dct_count, overflow, test_has_ended);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1, 2'($urandom), 0, 0, 0, 1);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec() !== 71'd0) begin n_bad++; $display("FAIL midreset_async got %h want 0", dut_vec()); end
    m_reset();
    @(posedge clk);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 0, 0, 0, 1);
      n_cmp++;
      if (out_valid !== 1'b0 || dut_vec() !== m_vec()) begin n_bad++; $display("FAIL midreset_after got %h want %h", dut_vec(), m_vec()); end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_fill();
    test_backpressure();
    test_timeout();
    test_flush();
    test_random();
    test_drain();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
